// File: rtl/goertzel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : goertzel_pkg
// Description : Shared constants for the Goertzel enable-strobe path.
// Revision    : 1.0 - initial release
// ============================================================================
package goertzel_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_ACQ  = 2'd1;
    localparam state_t c_LOCK = 2'd2;

    // Matches the enable generator's divide ratio.
    localparam int c_DEF_EXP_PERIOD = 1000;

endpackage : goertzel_pkg
`default_nettype wire

// File: rtl/en_mon_if.sv
`default_nettype none
// ============================================================================
// Module      : en_mon_if
// Description : Strobe input and status outputs of the enable-period monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface en_mon_if #(
    parameter int W = 12
);
    logic         en_in;
    logic         clr;
    logic [W-1:0] period_o;
    logic         period_vld;
    logic         locked;
    logic         err_period;
    logic         err_timeout;
    logic [7:0]   miss_cnt;

    modport master (
        output en_in, clr,
        input  period_o, period_vld, locked, err_period, err_timeout, miss_cnt
    );

    modport slave (
        input  en_in, clr,
        output period_o, period_vld, locked, err_period, err_timeout, miss_cnt
    );
endinterface : en_mon_if
`default_nettype wire

// File: rtl/en_period_cnt.sv
`default_nettype none
// ============================================================================
// Module      : en_period_cnt
// Description : Saturating W-bit up counter with synchronous zero.
// Revision    : 1.0 - initial release
// ============================================================================
module en_period_cnt #(
    parameter int W = 12
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_zero,
    output logic [W-1:0]      o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_zero) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule : en_period_cnt
`default_nettype wire

// File: rtl/en_mon.sv
`default_nettype none
// ============================================================================
// Module      : en_mon
// Description : Enable-strobe period monitor with lock, error and loss flags.
// Revision    : 1.0 - initial release
// ============================================================================
module en_mon
    import goertzel_pkg::*;
#(
    parameter int W          = 12,
    parameter int EXP_PERIOD = c_DEF_EXP_PERIOD,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 2000
) (
    input  wire logic clk,
    input  wire logic rst,
    en_mon_if.slave   bus
);
    localparam logic [W:0]   c_EXP      = (W+1)'(EXP_PERIOD);
    localparam logic [W:0]   c_TOL      = (W+1)'(TOL);
    localparam logic [W-1:0] c_TIMEOUT  = W'(TIMEOUT);
    localparam logic [3:0]   c_LOCK_CNT = 4'(LOCK_CNT);

    state_t       r_state, w_state_nxt;
    logic [3:0]   r_mcnt, w_mcnt_nxt, w_mcnt_inc;
    logic [W-1:0] w_cnt, w_period;
    logic [W:0]   w_diff, w_dev;
    logic         w_event, w_in_tol, w_timeout;
    logic         w_pvld_nxt, w_set_errp, w_set_errt, w_miss_inc;

    logic [W-1:0] r_period;
    logic         r_pvld, r_locked, r_errp, r_errt;
    logic [7:0]   r_miss;

    assign w_event = bus.en_in;

    en_period_cnt #(.W(W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_zero (bus.clr | bus.en_in),
        .o_cnt  (w_cnt)
    );

    // Period is counted inclusively of the event cycle itself.
    assign w_period   = w_cnt + 1'b1;
    assign w_diff     = {1'b0, w_period} - c_EXP;
    assign w_dev      = w_diff[W] ? (~w_diff + 1'b1) : w_diff;
    assign w_in_tol   = (w_dev <= c_TOL);
    assign w_timeout  = (w_cnt == c_TIMEOUT);
    assign w_mcnt_inc = r_mcnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A real event outranks a coincident timeout: it carries a measurement.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clr) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: if (w_event) w_state_nxt = c_ACQ;
                c_ACQ: begin
                    if (w_event) begin
                        if (w_in_tol && (w_mcnt_inc == c_LOCK_CNT)) w_state_nxt = c_LOCK;
                    end else if (w_timeout) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                c_LOCK: begin
                    if (w_event) begin
                        if (!w_in_tol) w_state_nxt = c_ACQ;
                    end else if (w_timeout) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pvld_nxt = 1'b0;
        w_mcnt_nxt = r_mcnt;
        w_set_errp = 1'b0;
        w_set_errt = 1'b0;
        w_miss_inc = 1'b0;
        case (r_state)
            c_IDLE: if (w_event) w_mcnt_nxt = 4'd0;
            c_ACQ: begin
                if (w_event) begin
                    w_pvld_nxt = 1'b1;
                    w_mcnt_nxt = w_in_tol ? w_mcnt_inc : 4'd0;
                end
            end
            c_LOCK: begin
                if (w_event) begin
                    w_pvld_nxt = 1'b1;
                    if (!w_in_tol) begin
                        w_set_errp = 1'b1;
                        w_miss_inc = 1'b1;
                        w_mcnt_nxt = 4'd0;
                    end
                end else if (w_timeout) begin
                    w_set_errt = 1'b1;
                    w_miss_inc = 1'b1;
                end
            end
            default: w_mcnt_nxt = 4'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcnt   <= 4'd0;
            r_period <= '0;
            r_pvld   <= 1'b0;
            r_locked <= 1'b0;
            r_errp   <= 1'b0;
            r_errt   <= 1'b0;
            r_miss   <= 8'd0;
        end else if (bus.clr) begin
            // period_o deliberately survives a clear.
            r_mcnt   <= 4'd0;
            r_pvld   <= 1'b0;
            r_locked <= 1'b0;
            r_errp   <= 1'b0;
            r_errt   <= 1'b0;
            r_miss   <= 8'd0;
        end else begin
            r_mcnt   <= w_mcnt_nxt;
            r_pvld   <= w_pvld_nxt;
            r_locked <= (w_state_nxt == c_LOCK);
            if (w_pvld_nxt)                     r_period <= w_period;
            if (w_set_errp)                     r_errp   <= 1'b1;
            if (w_set_errt)                     r_errt   <= 1'b1;
            if (w_miss_inc && (r_miss != 8'hFF)) r_miss   <= r_miss + 8'd1;
        end
    end

    assign bus.period_o    = r_period;
    assign bus.period_vld  = r_pvld;
    assign bus.locked      = r_locked;
    assign bus.err_period  = r_errp;
    assign bus.err_timeout = r_errt;
    assign bus.miss_cnt    = r_miss;
endmodule : en_mon
`default_nettype wire

// File: tb/tb_en_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_en_mon
// Description : Directed plus randomized bench for en_mon against a timestamp model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_en_mon;
    localparam int W        = 12;
    localparam int EXP      = 1000;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    en_mon_if #(.W(W)) bus ();

    en_mon #(
        .W(W), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: events are timestamps, period is the edge-count gap.
    int edge_no = 0;
    int m_last, m_run, m_miss, m_period;
    bit m_active, m_locked, m_pvld, m_errp, m_errt;

    function automatic void model_reset();
        m_active = 0; m_locked = 0; m_pvld = 0; m_errp = 0; m_errt = 0;
        m_run = 0; m_miss = 0; m_period = 0; m_last = edge_no;
    endfunction

    function automatic void model_edge(input bit e, input bit c);
        int  gap;
        bit  good;
        m_pvld = 0;
        if (c) begin
            m_active = 0; m_locked = 0; m_run = 0;
            m_errp = 0; m_errt = 0; m_miss = 0; m_last = edge_no;
        end else if (e) begin
            if (!m_active) begin
                m_active = 1;
                m_run    = 0;
            end else begin
                gap      = edge_no - m_last;
                good     = (gap >= EXP - TOL) && (gap <= EXP + TOL);
                m_pvld   = 1;
                m_period = gap;
                if (m_locked) begin
                    if (!good) begin
                        m_errp = 1; m_locked = 0; m_run = 0;
                        if (m_miss < 255) m_miss++;
                    end
                end else if (good) begin
                    m_run++;
                    if (m_run == LOCK_CNT) m_locked = 1;
                end else begin
                    m_run = 0;
                end
            end
            m_last = edge_no;
        end else if (m_active && (edge_no - m_last - 1 == TIMEOUT)) begin
            if (m_locked) begin
                m_errt = 1;
                if (m_miss < 255) m_miss++;
            end
            m_active = 0;
            m_locked = 0;
        end
    endfunction

    function automatic logic [23:0] model_vec();
        logic [W-1:0] p;
        logic [7:0]   mc;
        p  = W'(m_period);
        mc = 8'(m_miss);
        return {p, m_pvld, m_locked, m_errp, m_errt, mc};
    endfunction

    logic [23:0] dut_v;
    assign dut_v = {bus.period_o, bus.period_vld, bus.locked,
                    bus.err_period, bus.err_timeout, bus.miss_cnt};

    task automatic step(input bit e, input bit c);
        bus.en_in = e;
        bus.clr   = c;
        @(posedge clk);
        edge_no++;
        model_edge(e, c);
        #1;
        check("outs", {8'd0, dut_v}, {8'd0, model_vec()});
        bus.en_in = 1'b0;
        bus.clr   = 1'b0;
    endtask

    task automatic evt_after(input int gap);
        repeat (gap - 1) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        check("async_rst", {8'd0, dut_v}, 32'd0);
        model_reset();
        @(posedge clk);
        edge_no++;
        #1 rst = 1'b0;
    endtask

    initial begin
        int r;
        rst       = 1'b1;
        bus.en_in = 1'b0;
        bus.clr   = 1'b0;
        model_reset();
        @(posedge clk);
        edge_no++;
        #1;
        check("reset_state", {8'd0, dut_v}, 32'd0);
        rst = 1'b0;

        // Six events at the nominal period.
        step(1'b1, 1'b0);
        check("ev1_no_vld", 32'(bus.period_vld), 32'd0);
        for (int i = 2; i <= 6; i++) begin
            evt_after(1000);
            check("nom_vld", 32'(bus.period_vld), 32'd1);
            check("nom_period", 32'(bus.period_o), 32'd1000);
            if (i == 4) check("not_yet_locked", 32'(bus.locked), 32'd0);
            if (i == 5) check("locked_ev5", 32'(bus.locked), 32'd1);
        end
        check("nom_no_errp", 32'(bus.err_period), 32'd0);
        check("nom_no_errt", 32'(bus.err_timeout), 32'd0);

        // Short period while locked.
        evt_after(998);
        check("short_period", 32'(bus.period_o), 32'd998);
        check("short_errp", 32'(bus.err_period), 32'd1);
        check("short_miss", 32'(bus.miss_cnt), 32'd1);
        check("short_unlock", 32'(bus.locked), 32'd0);
        repeat (5) evt_after(1000);
        check("relock", 32'(bus.locked), 32'd1);

        // Clear coincident with an in-lock event.
        repeat (999) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("clr_no_vld", 32'(bus.period_vld), 32'd0);
        check("clr_unlock", 32'(bus.locked), 32'd0);
        check("clr_errp", 32'(bus.err_period), 32'd0);
        check("clr_miss", 32'(bus.miss_cnt), 32'd0);
        check("clr_hold_period", 32'(bus.period_o), 32'd1000);

        // Lock, then let events stop.
        step(1'b1, 1'b0);
        repeat (4) evt_after(1000);
        check("lock_again", 32'(bus.locked), 32'd1);
        repeat (2000) step(1'b0, 1'b0);
        check("pre_timeout", 32'(bus.locked), 32'd1);
        step(1'b0, 1'b0);
        check("to_errt", 32'(bus.err_timeout), 32'd1);
        check("to_unlock", 32'(bus.locked), 32'd0);
        check("to_miss", 32'(bus.miss_cnt), 32'd1);
        step(1'b1, 1'b0);
        check("idle_evt_no_vld", 32'(bus.period_vld), 32'd0);

        // Back-to-back strobe while locked.
        repeat (4) evt_after(1000);
        check("lock_b2b", 32'(bus.locked), 32'd1);
        evt_after(1000);
        evt_after(1);
        check("b2b_period", 32'(bus.period_o), 32'd1);
        check("b2b_errp", 32'(bus.err_period), 32'd1);
        check("b2b_unlock", 32'(bus.locked), 32'd0);

        // Asynchronous reset in the middle of lock.
        repeat (4) evt_after(1000);
        check("lock_pre_rst", 32'(bus.locked), 32'd1);
        repeat (500) step(1'b0, 1'b0);
        do_reset();
        evt_after(1000);
        check("post_rst_no_vld", 32'(bus.period_vld), 32'd0);

        // Randomized gaps around the nominal period, glitches, stalls and clears.
        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       evt_after(998 + int'($urandom_range(0, 4)));
            else if (r == 6) evt_after(int'($urandom_range(1, 5)));
            else if (r == 7) evt_after(int'($urandom_range(2010, 2100)));
            else if (r == 8) begin
                step(1'b0, 1'b1);
                evt_after(1000);
            end else begin
                repeat (999) step(1'b0, 1'b0);
                step(1'b1, ($urandom_range(0, 3) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule : tb_en_mon
`default_nettype wire
